// File: rtl/scr_pkg.sv
// Shared types and constants for the text screen buffer controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scr_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int DEF_COLS  = 16;
    localparam int DEF_ROWS  = 4;
    localparam int NCELL     = DEF_COLS * DEF_ROWS;
    localparam int IW        = $clog2(NCELL);

    localparam logic [7:0] DEF_FILL    = 8'h20;
    localparam logic [7:0] CH_BS       = 8'h08;
    localparam logic [7:0] CH_LF       = 8'h0A;
    localparam logic [7:0] CH_FF       = 8'h0C;
    localparam logic [7:0] CH_CR       = 8'h0D;
    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;

    // Round-robin history encoding: which requester won the last contention.
    localparam logic RR_CPU  = 1'b0;
    localparam logic RR_TERM = 1'b1;

    function automatic logic is_print(input logic [7:0] c);
        return (c >= CH_PRINT_LO) && (c <= CH_PRINT_HI);
    endfunction

endpackage

// File: rtl/screen_buffer_ctrl_if.sv
// Bundle of CPU write, terminal stream, clear control and text-engine read signals.
// Latency: n/a (wiring only).
// Backpressure: cpu_wr_ack / term_ready are the producers' only stall indication.
interface screen_buffer_ctrl_if;

    logic                   cpu_wr_req;
    logic [scr_pkg::IW-1:0] cpu_wr_idx;
    logic [7:0]             cpu_wr_char;
    logic                   cpu_wr_ack;

    logic                   term_valid;
    logic [7:0]             term_char;
    logic                   term_ready;

    logic                   clr_req;
    logic                   clr_busy;

    logic [scr_pkg::IW-1:0] rd_addr;
    logic [7:0]             rd_char;
    logic [scr_pkg::IW-1:0] cursor;

    modport master (
        output cpu_wr_req, cpu_wr_idx, cpu_wr_char, term_valid, term_char, clr_req, rd_addr,
        input  cpu_wr_ack, term_ready, clr_busy, rd_char, cursor
    );

    modport slave (
        input  cpu_wr_req, cpu_wr_idx, cpu_wr_char, term_valid, term_char, clr_req, rd_addr,
        output cpu_wr_ack, term_ready, clr_busy, rd_char, cursor
    );

endinterface

// File: rtl/scr_rr_arb2.sv
// Two-way round-robin arbiter: req[0]=CPU, req[1]=terminal; history favours the loser of the last tie.
// Latency: grant is combinational in the request cycle; history updates on the clock edge.
// Backpressure: en low forces no grant; requesters simply stay pending.
module scr_rr_arb2
    import scr_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic rr_last;

    // Grant the sole requester, or on a tie the one that did not win last time.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (rr_last == RR_TERM) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // History only moves on a contended grant; reset favours the CPU on the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= RR_TERM;
        end else if (en && (req == 2'b11)) begin
            rr_last <= gnt[1] ? RR_TERM : RR_CPU;
        end
    end

endmodule

// File: rtl/screen_buffer_ctrl.sv
// Owns the 64-cell text buffer: arbitrates CPU/terminal writes, decodes terminal control codes, runs clear sweeps.
// Latency: writes commit on the grant edge; rd_char is registered, 1 cycle after rd_addr, read-before-write.
// Backpressure: ack/ready low during a clear sweep or when the other requester wins; the read port never stalls.
module screen_buffer_ctrl
    import scr_pkg::*;
#(
    parameter int         COLS      = DEF_COLS,
    parameter int         ROWS      = DEF_ROWS,
    parameter logic [7:0] FILL_CHAR = DEF_FILL
)
(
    input  logic                clk,
    input  logic                rst_n,
    screen_buffer_ctrl_if.slave bus
);

    localparam int            NC       = COLS * ROWS;
    localparam logic [IW-1:0] COL_STEP = IW'(COLS);
    localparam logic [IW-1:0] ROW_MASK = ~IW'(COLS - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NC - 1);

    state_t          state;
    logic [IW-1:0]   sweep_idx;
    logic [IW-1:0]   cursor_q;
    logic            clr_busy_q;
    logic [7:0]      rd_q;
    logic [7:0]      mem [NC];

    logic            arb_en;
    logic [1:0]      gnt;
    logic            cpu_gnt;
    logic            term_gnt;

    logic            wr_en;
    logic [IW-1:0]   wr_idx;
    logic [7:0]      wr_dat;

    // Writes are only arbitrated in IDLE when no clear is being requested.
    assign arb_en = (state == ST_IDLE) && !bus.clr_req;

    scr_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .req   ({bus.term_valid, bus.cpu_wr_req}),
        .gnt   (gnt)
    );

    assign cpu_gnt        = gnt[0];
    assign term_gnt       = gnt[1];
    assign bus.cpu_wr_ack = cpu_gnt;
    assign bus.term_ready = term_gnt;
    assign bus.clr_busy   = clr_busy_q;
    assign bus.cursor     = cursor_q;
    assign bus.rd_char    = rd_q;

    // Single write port select: sweep, then CPU, then terminal printable/backspace.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = sweep_idx;
        wr_dat = FILL_CHAR;
        if (state == ST_CLEAR) begin
            wr_en = 1'b1;
        end else if (cpu_gnt) begin
            wr_en  = 1'b1;
            wr_idx = bus.cpu_wr_idx;
            wr_dat = bus.cpu_wr_char;
        end else if (term_gnt) begin
            if (is_print(bus.term_char)) begin
                wr_en  = 1'b1;
                wr_idx = cursor_q;
                wr_dat = bus.term_char;
            end else if ((bus.term_char == CH_BS) && (cursor_q != '0)) begin
                wr_en  = 1'b1;
                wr_idx = cursor_q - IW'(1);
            end
        end
    end

    // Cell array in flops so reset can fill every cell at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NC; i++) begin
                mem[i] <= FILL_CHAR;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_dat;
        end
    end

    // Read port samples the array before this cycle's write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= FILL_CHAR;
        end else begin
            rd_q <= mem[bus.rd_addr];
        end
    end

    // Control FSM: cursor movement, clear entry (request or form feed) and sweep counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sweep_idx  <= '0;
            cursor_q   <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.clr_req) begin
                        state      <= ST_CLEAR;
                        sweep_idx  <= '0;
                        cursor_q   <= '0;
                        clr_busy_q <= 1'b1;
                    end else if (term_gnt) begin
                        case (bus.term_char)
                            CH_CR: cursor_q <= cursor_q & ROW_MASK;
                            CH_LF: cursor_q <= cursor_q + COL_STEP;
                            CH_BS: begin
                                if (cursor_q != '0) begin
                                    cursor_q <= cursor_q - IW'(1);
                                end
                            end
                            CH_FF: begin
                                state      <= ST_CLEAR;
                                sweep_idx  <= '0;
                                cursor_q   <= '0;
                                clr_busy_q <= 1'b1;
                            end
                            default: begin
                                if (is_print(bus.term_char)) begin
                                    cursor_q <= cursor_q + IW'(1);
                                end
                            end
                        endcase
                    end
                end
                ST_CLEAR: begin
                    sweep_idx <= sweep_idx + IW'(1);
                    if (sweep_idx == LAST_IDX) begin
                        state      <= ST_IDLE;
                        clr_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    clr_busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_screen_buffer_ctrl.sv
// Directed bench for screen_buffer_ctrl: reset fill, arbitration, terminal codes, clear sweeps, async reset.
// Latency: expectations assume a 1-cycle registered read and combinational ack/ready.
// Backpressure: every wait on ack/ready/busy is cycle-bounded.
module tb_screen_buffer_ctrl;
    import scr_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    screen_buffer_ctrl_if bus ();

    screen_buffer_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cell(input int idx, input logic [7:0] exp);
        bus.rd_addr = IW'(idx);
        step();
        check($sformatf("cell%0d", idx), bus.rd_char, exp);
    endtask

    task automatic term_send(input logic [7:0] ch);
        bus.term_valid = 1'b1;
        bus.term_char  = ch;
        @(negedge clk);
        for (int w = 0; w < 200 && !bus.term_ready; w++) @(negedge clk);
        if (!bus.term_ready) check($sformatf("term_timeout_%0h", ch), bus.term_ready, 1);
        step();
        bus.term_valid = 1'b0;
    endtask

    task automatic term_str(input string s);
        for (int i = 0; i < s.len(); i++) term_send(s[i]);
    endtask

    task automatic cpu_write(input int idx, input logic [7:0] ch);
        bus.cpu_wr_req  = 1'b1;
        bus.cpu_wr_idx  = IW'(idx);
        bus.cpu_wr_char = ch;
        @(negedge clk);
        for (int w = 0; w < 200 && !bus.cpu_wr_ack; w++) @(negedge clk);
        if (!bus.cpu_wr_ack) check($sformatf("cpu_timeout_%0d", idx), bus.cpu_wr_ack, 1);
        step();
        bus.cpu_wr_req = 1'b0;
    endtask

    // Count busy cycles from the current point; drops clr_req/term_valid part-way to show they are ignored.
    task automatic count_busy(input string tag, output int busy_cnt, output int stall_hits);
        busy_cnt   = 0;
        stall_hits = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!bus.clr_busy) break;
            busy_cnt++;
            if (bus.cpu_wr_ack || bus.term_ready) stall_hits++;
            if (busy_cnt == 10) bus.clr_req = 1'b0;
            if (busy_cnt == 60) bus.term_valid = 1'b0;
        end
        check({tag, "_busy_cycles"}, busy_cnt, 64);
        check({tag, "_grants_in_busy"}, stall_hits, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int stall_hits;

        bus.cpu_wr_req  = 1'b0;
        bus.cpu_wr_idx  = '0;
        bus.cpu_wr_char = 8'h00;
        bus.term_valid  = 1'b0;
        bus.term_char   = 8'h00;
        bus.clr_req     = 1'b0;
        bus.rd_addr     = '0;

        // 1: reset values and full reset fill
        repeat (2) step();
        check("rst_rd_char", bus.rd_char, 8'h20);
        check("rst_cursor", bus.cursor, 0);
        check("rst_busy", bus.clr_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 64; i++) check_cell(i, 8'h20);

        // 2: CPU and terminal contend; CPU wins first tie, then alternation
        bus.cpu_wr_req  = 1'b1;
        bus.cpu_wr_idx  = 6'd5;
        bus.cpu_wr_char = "X";
        bus.term_valid  = 1'b1;
        bus.term_char   = "A";
        @(negedge clk);
        check("arb_c0_ack", bus.cpu_wr_ack, 1);
        check("arb_c0_rdy", bus.term_ready, 0);
        step();
        bus.cpu_wr_idx  = 6'd6;
        bus.cpu_wr_char = "Y";
        @(negedge clk);
        check("arb_c1_ack", bus.cpu_wr_ack, 0);
        check("arb_c1_rdy", bus.term_ready, 1);
        step();
        bus.term_char = "B";
        @(negedge clk);
        check("arb_c2_ack", bus.cpu_wr_ack, 1);
        check("arb_c2_rdy", bus.term_ready, 0);
        step();
        bus.cpu_wr_req = 1'b0;
        @(negedge clk);
        check("arb_c3_ack", bus.cpu_wr_ack, 0);
        check("arb_c3_rdy", bus.term_ready, 1);
        step();
        bus.term_valid = 1'b0;
        check("arb_cursor", bus.cursor, 2);
        check_cell(5, "X");
        check_cell(6, "Y");
        check_cell(0, "A");
        check_cell(1, "B");

        // 3: printable run, CR, LF and LF wrap
        for (int i = 0; i < 12; i++) term_send(".");
        check("cur_run14", bus.cursor, 14);
        term_str("AB");
        check("cur_after_ab", bus.cursor, 16);
        term_send(CH_CR);
        check("cur_cr16", bus.cursor, 16);
        term_send(CH_LF);
        check("cur_lf32", bus.cursor, 32);
        term_send("C");
        check("cur_c33", bus.cursor, 33);
        term_send(CH_CR);
        check("cur_cr32", bus.cursor, 32);
        term_send(CH_LF);
        term_send(CH_LF);
        check("cur_lf_wrap", bus.cursor, 0);
        check_cell(13, ".");
        check_cell(14, "A");
        check_cell(15, "B");
        check_cell(32, "C");

        // 4: BS at 0, wrap 63->0, discarded bytes, printable upper bound, BS mid-row
        term_send(CH_BS);
        check("bs_at0", bus.cursor, 0);
        term_send(CH_LF);
        term_send(CH_LF);
        term_send(CH_LF);
        for (int i = 0; i < 15; i++) term_send(".");
        check("cur63", bus.cursor, 63);
        term_send("Z");
        check("cur_wrap0", bus.cursor, 0);
        term_send(CH_BS);
        check("bs_at0_again", bus.cursor, 0);
        check_cell(63, "Z");
        term_send(8'h01);
        term_send(8'h7F);
        check("discard_cursor", bus.cursor, 0);
        term_send(8'h7E);
        check("tilde_cursor", bus.cursor, 1);
        term_str("..");
        term_send(CH_BS);
        check("bs_at3", bus.cursor, 2);
        check_cell(0, 8'h7E);
        check_cell(1, ".");
        check_cell(2, 8'h20);

        // 5a: clr_req with CPU pending; held clr_req must not re-trigger
        bus.clr_req     = 1'b1;
        bus.cpu_wr_req  = 1'b1;
        bus.cpu_wr_idx  = 6'd10;
        bus.cpu_wr_char = "Q";
        @(negedge clk);
        check("clr_c0_ack", bus.cpu_wr_ack, 0);
        check("clr_c0_busy", bus.clr_busy, 0);
        step();
        count_busy("clr", busy_cnt, stall_hits);
        check("clr_ack_after", bus.cpu_wr_ack, 1);
        step();
        bus.cpu_wr_req = 1'b0;
        check("clr_cursor", bus.cursor, 0);
        for (int i = 0; i < 64; i++) check_cell(i, (i == 10) ? 8'h51 : 8'h20);

        // 5b: form feed clears like clr_req; a held FF is ignored while busy
        term_str("ab");
        check("ff_pre_cursor", bus.cursor, 2);
        term_send(CH_FF);
        bus.term_valid = 1'b1;
        bus.term_char  = CH_FF;
        count_busy("ff", busy_cnt, stall_hits);
        step();
        check("ff_cursor", bus.cursor, 0);
        check_cell(0, 8'h20);
        check_cell(1, 8'h20);
        check_cell(10, 8'h20);

        // 6a: read-before-write on a CPU write to the address being read
        bus.rd_addr     = 6'd20;
        bus.cpu_wr_req  = 1'b1;
        bus.cpu_wr_idx  = 6'd20;
        bus.cpu_wr_char = "M";
        @(negedge clk);
        check("rbw_ack", bus.cpu_wr_ack, 1);
        step();
        bus.cpu_wr_req = 1'b0;
        check("rbw_old", bus.rd_char, 8'h20);
        step();
        check("rbw_new", bus.rd_char, "M");

        // 6b: async reset at sweep cycle 30 while reading the cell being swept
        cpu_write(30, "P");
        cpu_write(40, "N");
        bus.rd_addr = 6'd30;
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        repeat (30) step();
        check("mid_busy", bus.clr_busy, 1);
        check("mid_rd_old", bus.rd_char, "P");
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rd_char", bus.rd_char, 8'h20);
        check("arst_busy", bus.clr_busy, 0);
        check("arst_cursor", bus.cursor, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_cell(40, 8'h20);
        check_cell(30, 8'h20);
        check_cell(20, 8'h20);

        // 6c: round-robin history is back to CPU-first after reset
        bus.cpu_wr_req  = 1'b1;
        bus.cpu_wr_idx  = 6'd7;
        bus.cpu_wr_char = "R";
        bus.term_valid  = 1'b1;
        bus.term_char   = "T";
        @(negedge clk);
        check("post_rst_ack", bus.cpu_wr_ack, 1);
        check("post_rst_rdy", bus.term_ready, 0);
        step();
        bus.cpu_wr_req = 1'b0;
        bus.term_valid = 1'b0;
        check_cell(7, "R");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
